// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with a registered read port, occupancy count and status flags.
// All DEPTH entries are usable; full and empty are told apart by the separate count register.
module sync_fifo_flags #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int AE_THRESH = 8,
   parameter int AF_THRESH = 248
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              w_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              r_en,
   output logic [DATA_W-1:0] data_out,
   output logic              r_valid,
   output logic [ADDR_W:0]   count,
   output logic              full_flag,
   output logic              empty_flag,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              half_flag,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] HALF_C  = (ADDR_W + 1)'(DEPTH / 2);
   localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_THRESH);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_THRESH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
   logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              r_valid_q, r_valid_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              wa, ra;

   // Flags are pure decodes of the registered occupancy.
   assign full_flag    = (count_q == DEPTH_C);
   assign empty_flag   = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign half_flag    = (count_q >= HALF_C);

   assign data_out  = data_out_q;
   assign r_valid   = r_valid_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   always_comb begin
      wa          = w_en & ~full_flag;
      ra          = r_en & ~empty_flag;
      w_ptr_d     = wa ? w_ptr_q + 1'b1 : w_ptr_q;
      r_ptr_d     = ra ? r_ptr_q + 1'b1 : r_ptr_q;
      data_out_d  = ra ? mem[r_ptr_q] : data_out_q;
      r_valid_d   = ra;
      overflow_d  = w_en & full_flag;
      underflow_d = r_en & empty_flag;
      count_d     = count_q;
      case ({wa, ra})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_ptr_q     <= '0;
         r_ptr_q     <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         r_valid_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         w_ptr_q     <= w_ptr_d;
         r_ptr_q     <= r_ptr_d;
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         r_valid_q   <= r_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not reset; a write coinciding with rst is dropped.
   always_ff @(posedge clk) begin
      if (!rst && wa) begin
         mem[w_ptr_q] <= data_in;
      end
   end

endmodule
